// File: rtl/read_polyq_stream_pkg.sv
// Shared constants, the reader state encoding and the length clamp for the polyQ stream reader.
package read_polyq_stream_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 13;
  localparam int N_COEF = 757;
  localparam int Q      = 4591;

  localparam logic [DATA_W-1:0] Q_W      = DATA_W'(Q);
  localparam logic [DATA_W-1:0] HALF_Q_W = DATA_W'((Q - 1) / 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  // Requests longer than the polynomial are cut down to a full sweep.
  function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] len);
    return (len > ADDR_W'(N_COEF)) ? ADDR_W'(N_COEF) : len;
  endfunction

endpackage

// File: rtl/read_polyq_stream_skid_fifo.sv
// Two-entry FIFO carrying {last, coefficient}; a push and a pop may share a cycle even when full.
module read_polyq_stream_skid_fifo #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/read_polyq_stream.sv
// Sweeps the polyQ RAM from address 0 to len-1 and streams coefficients over valid/ready.
// Define CENTER_LIFT_EN to map each coefficient c to c-Q when c > (Q-1)/2.
module read_polyq_stream
  import read_polyq_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_output_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              read_done_o
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] len_q, rd_cnt_q, beat_q, len_eff;
  logic              inflight_q, inflight_last_q;
  logic              fifo_empty, fifo_full;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_rdata;
  logic [DATA_W-1:0] coef, coef_out;
  logic [2:0]        credit;
  logic              pop, issue, last_issue, last_beat;

  assign len_eff     = clamp_len(len_i);
  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;
  assign last_issue  = (rd_cnt_q == len_q - ADDR_W'(1));
  assign last_beat   = (beat_q == len_q - ADDR_W'(1));

  // A beat leaving this cycle frees its slot before the new read can land, keeping 1 beat/cycle.
  assign credit = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == ST_STREAM) && (credit < 3'd2) && !(fifo_full && !pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = (len_eff == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (issue && last_issue) state_d = ST_DRAIN;
      ST_DRAIN:  if (pop && last_beat) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q           <= '0;
      rd_cnt_q        <= '0;
      beat_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        len_q    <= len_eff;
        rd_cnt_q <= '0;
        beat_q   <= '0;
      end else begin
        if (issue) rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
        if (pop)   beat_q   <= beat_q + ADDR_W'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
    end
  end

  read_polyq_stream_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, mem_output_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign coef = fifo_rdata[DATA_W-1:0];

`ifdef CENTER_LIFT_EN
  assign coef_out = (coef > HALF_Q_W) ? coef - Q_W : coef;
`else
  assign coef_out = coef;
`endif

  assign out_data_o  = out_valid_o ? coef_out : '0;
  assign out_last_o  = out_valid_o && fifo_rdata[DATA_W];
  assign mem_en_o    = issue;
  assign mem_addr_o  = rd_cnt_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign read_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_read_polyq_stream.sv
// Directed bench for read_polyq_stream against a 1-cycle-latency RAM model holding RAM[i]=i.
module tb_read_polyq_stream;
  import read_polyq_stream_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_output;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              read_done;

  logic [DATA_W-1:0] ram [0:2047];
  logic [DATA_W-1:0] ram_q = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) ram_q <= ram[mem_addr];
  assign mem_output = ram_q;

  read_polyq_stream dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .len_i        (len),
    .mem_en_o     (mem_en),
    .mem_addr_o   (mem_addr),
    .mem_output_i (mem_output),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last),
    .busy_o       (busy),
    .read_done_o  (read_done)
  );

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_en, out_valid, out_last, busy, read_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {mem_en, out_valid, out_last, busy, read_done});
    end
    checks++;
    if (mem_addr !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_addr_data got addr=%0d data=%0d exp 0/0", mem_addr, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    start = 1'b1; len = 11'd8;
    @(negedge clk);
    start = 1'b0; len = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== '0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_first_cycle got busy=%b en=%b addr=%0d valid=%b exp 1/1/0/0",
               busy, mem_en, mem_addr, out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency got valid=%b exp=0", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(k) || out_last !== 1'(k == 7)) begin
        failures++;
        $display("FAIL basic_beat%0d got valid=%b data=%0d last=%b exp 1/%0d/%0d",
                 k, out_valid, out_data, out_last, k, k == 7);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (read_done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got done=%b valid=%b exp 1/0", read_done, out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (read_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got done=%b busy=%b exp 0/0", read_done, busy);
    end
  endtask

  task automatic test_len_zero;
    int reads = 0;
    @(negedge clk);
    start = 1'b1; len = '0;
    #1;
    if (mem_en) reads++;
    @(negedge clk);
    start = 1'b0;
    #1;
    if (mem_en) reads++;
    checks++;
    if (read_done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL len0_done got done=%b valid=%b exp 1/0", read_done, out_valid);
    end
    @(negedge clk); #1;
    if (mem_en) reads++;
    checks++;
    if (busy !== 1'b0 || read_done !== 1'b0 || out_valid !== 1'b0 || reads != 0) begin
      failures++;
      $display("FAIL len0_after got busy=%b done=%b valid=%b reads=%0d exp 0/0/0/0",
               busy, read_done, out_valid, reads);
    end
  endtask

  task automatic test_backpressure;
    int exp = 0, issued = 0, lasts = 0;
    bit done = 0, hold = 0;
    logic [DATA_W-1:0] held_d = '0;
    logic held_l = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 11'd20; out_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 16);
      if (cyc == 3) begin start = 1'b1; len = 11'd3; end
      else begin start = 1'b0; len = '0; end
      #1;
      if (mem_en) issued++;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got valid=%b data=%0d last=%b exp 1/%0d/%b",
                   cyc, out_valid, out_data, out_last, held_d, held_l);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== DATA_W'(exp) || out_last !== 1'(exp == 19)) begin
          failures++;
          $display("FAIL bp_beat got data=%0d last=%b exp %0d/%0d", out_data, out_last, exp, exp == 19);
        end
        if (out_last) lasts++;
        exp++;
      end
      checks++;
      if (issued - exp > 2) begin
        failures++;
        $display("FAIL bp_outstanding got=%0d exp<=2", issued - exp);
      end
      if (read_done) done = 1;
      hold = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    checks++;
    if (!done || exp != 20 || lasts != 1) begin
      failures++;
      $display("FAIL bp_total got done=%0d beats=%0d lasts=%0d exp 1/20/1", done, exp, lasts);
    end
  endtask

  task automatic test_random_stream;
    int exp = 0, issued = 0, lasts = 0;
    bit done = 0, hold = 0;
    logic [DATA_W-1:0] held_d = '0;
    logic held_l = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 11'd757;
    @(negedge clk);
    start = 1'b0; len = '0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (mem_en) issued++;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          failures++;
          $display("FAIL rnd_hold cyc=%0d got data=%0d last=%b exp %0d/%b",
                   cyc, out_data, out_last, held_d, held_l);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== DATA_W'(exp) || out_last !== 1'(exp == 756)) begin
          failures++;
          $display("FAIL rnd_beat got data=%0d last=%b exp %0d/%0d", out_data, out_last, exp, exp == 756);
        end
        if (out_last) lasts++;
        exp++;
      end
      checks++;
      if (issued - exp > 2) begin
        failures++;
        $display("FAIL rnd_outstanding got=%0d exp<=2", issued - exp);
      end
      if (read_done) done = 1;
      hold = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (!done || exp != 757 || lasts != 1 || issued != 757) begin
      failures++;
      $display("FAIL rnd_total got done=%0d beats=%0d lasts=%0d reads=%0d exp 1/757/1/757",
               done, exp, lasts, issued);
    end
  endtask

  task automatic test_clamp;
    int beats = 0, last_at = -1;
    bit done = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 11'd1500;
    @(negedge clk);
    start = 1'b0; len = '0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      #1;
      if (out_valid) begin
        if (out_last) last_at = beats;
        beats++;
      end
      if (read_done) done = 1;
      @(negedge clk);
    end
    checks++;
    if (!done || beats != 757 || last_at != 756) begin
      failures++;
      $display("FAIL clamp got done=%0d beats=%0d last_at=%0d exp 1/757/756", done, beats, last_at);
    end
  endtask

  task automatic test_reset_mid_sweep;
    bit reached = 0;
    int dones = 0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 11'd757;
    @(negedge clk);
    start = 1'b0; len = '0;
    for (int cyc = 0; cyc < 400 && !reached; cyc++) begin
      #1;
      if (out_valid && out_data == DATA_W'(300)) reached = 1;
      else @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (!reached || {mem_en, out_valid, out_last, busy, read_done} !== 5'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got reached=%0d flags=%b data=%0d exp 1/00000/0",
               reached, {mem_en, out_valid, out_last, busy, read_done}, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (read_done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midrst_no_done got=%0d exp=0", dones);
    end
    start = 1'b1; len = 11'd4;
    @(negedge clk);
    start = 1'b0; len = '0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(k) || out_last !== 1'(k == 3)) begin
        failures++;
        $display("FAIL midrst_beat%0d got valid=%b data=%0d last=%b exp 1/%0d/%0d",
                 k, out_valid, out_data, out_last, k, k == 3);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (read_done !== 1'b1) begin
      failures++;
      $display("FAIL midrst_done got=%b exp=1", read_done);
    end
  endtask

`ifdef CENTER_LIFT_EN
  task automatic test_center_lift;
    logic [DATA_W-1:0] exp_tab [4];
    ram[0] = 13'd0; ram[1] = 13'd2295; ram[2] = 13'd2296; ram[3] = 13'd4590;
    exp_tab[0] = 13'd0; exp_tab[1] = 13'd2295; exp_tab[2] = -13'sd2295; exp_tab[3] = -13'sd1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 11'd4;
    @(negedge clk);
    start = 1'b0; len = '0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[k]) begin
        failures++;
        $display("FAIL lift%0d got valid=%b data=%0d exp 1/%0d", k, out_valid, out_data, exp_tab[k]);
      end
    end
    for (int i = 0; i < 4; i++) ram[i] = DATA_W'(i);
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = DATA_W'(i);
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_random_stream();
    test_clamp();
    test_reset_mid_sweep();
`ifdef CENTER_LIFT_EN
    test_center_lift();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
